serial_sub_4bit: RTL and testbench
==================================

# serial_sub_4bit

Bit-serial subtractor that inverts the 4-bit adder. It recovers one adder operand from the adder's 5-bit result {carry, sum} and the other operand, using one full-subtractor cell iterated LSB-first. It sits beside the adder as its reverse-direction datapath and as a cross-check: for any adder vector, feeding {carry,sum} and `a` returns `b`. Operands enter and results leave through valid/ready handshakes.

## Interface
Parameters:
- `WIDTH`, default 4: subtrahend width; minuend and difference are `WIDTH+1` bits.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  block can accept an operand pair.
- `minuend`  in  WIDTH+1  adder result {carry,sum}.
- `subtrahend`  in  WIDTH  known adder operand.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts result.
- `diff`  out  WIDTH+1  minuend − subtrahend, modulo 2^(WIDTH+1).
- `borrow`  out  1  set when minuend < subtrahend (zero-extended compare).

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE: `in_ready`=1. On `in_valid`: latch `minuend`, and latch `subtrahend` zero-extended to WIDTH+1 bits. Clear the bit counter and the borrow flop, then go to SHIFT.
- SHIFT: `in_ready`=0. Each cycle processes bit i (counter value):
  - d_i = m_i ^ s_i ^ bin
  - bout = (~m_i & s_i) | (~(m_i ^ s_i) & bin)
  - d_i shifts into the result register from the MSB side; bout updates the borrow flop; the counter increments.
- After bit WIDTH has been processed, go to DONE.
- DONE: `out_valid`=1. `diff` and `borrow` are stable and held unchanged while `out_ready`=0. On `out_ready`=1, go to IDLE.
- `borrow` is the final borrow-out of bit WIDTH.
- `in_valid` is ignored outside IDLE. Operand inputs are sampled only at the accept edge, so input changes during SHIFT/DONE have no effect.
- Width rule: all internal arithmetic is WIDTH+1 bits and there is no other overflow flag.
- Reset (`rst_n`=0 at a rising edge, any state, including mid-SHIFT): state=IDLE, counter=0, borrow flop=0, result register=0. Any in-flight operation is discarded and no `out_valid` is produced for it.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `diff`=0, `borrow`=0.
- Accept edge = the rising edge where IDLE and `in_valid`=1.
- `out_valid` rises exactly WIDTH+1 edges after the accept edge (5 for WIDTH=4).
- `out_valid` falls on the edge where `out_ready`=1; `in_ready` rises on the same edge.
- Minimum period per operation is WIDTH+3 cycles (7 for WIDTH=4): 1 accept + WIDTH+1 shift + 1 output handshake.
- `out_ready` already high when `out_valid` rises: the result is consumed on the first DONE edge.
- `in_ready` and `out_valid` are never high together.
- All outputs are registered (or decoded from the state register only); no combinational path from inputs to outputs.

## Structure
- Package `serial_sub_pkg`:
  - state enum typedef (IDLE, SHIFT, DONE);
  - default WIDTH constant;
  - counter-width localparam, $clog2(WIDTH+1).
- Sub-module `full_subtractor`:
  - inputs m, s, bin; outputs d, bout;
  - purely combinational, one instance, iterated in time.
- The top module holds the FSM, counter, operand shift registers, result register and borrow flop.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles → `in_ready`=1, `out_valid`=0, `diff`=0, `borrow`=0.
- Adder round-trip, minuend 5'b00011, subtrahend 4'b0001:
  - `out_valid` rises 5 edges after accept;
  - `diff`=5'b00010, `borrow`=0.
- Adder carry cases:
  - 5'b10000 − 4'b1111 → `diff`=5'b00001, `borrow`=0;
  - 5'b10100 − 4'b1010 → `diff`=5'b01010, `borrow`=0.
- Negative result: 5'b00011 − 4'b0101 → `diff`=5'b11110, `borrow`=1.
- Back-pressure:
  - hold `out_ready`=0 for 4 cycles in DONE → `diff`/`borrow` stable and `in_ready`=0 throughout;
  - a second `in_valid` pulse in this window is not accepted;
  - `out_ready`=1 → IDLE next edge.
- Reset mid-SHIFT: assert `rst_n`=0 at bit 2 → outputs return to reset values and no `out_valid` appears; the next operation 5'b00000 − 4'b0000 gives `diff`=0, `borrow`=0.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam int DEFAULT_WIDTH = 4;
    localparam int CNT_W         = $clog2(DEFAULT_WIDTH + 1);

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = m - s - bin, with borrow out.
module full_subtractor (
    input  logic m,
    input  logic s,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = m ^ s ^ bin;
    assign bout = (~m & s) | (~(m ^ s) & bin);

endmodule

// File: rtl/serial_sub_4bit.sv
// Bit-serial subtractor: recovers an adder operand from {carry,sum} and the
// other operand, one full-subtractor step per cycle, LSB first.
module serial_sub_4bit
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH:0]   minuend,
    input  logic [WIDTH-1:0] subtrahend,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   diff,
    output logic             borrow
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [WIDTH:0] m_q, m_d;
    logic [WIDTH:0] s_q, s_d;
    logic [WIDTH:0] res_q, res_d;
    logic           borrow_q, borrow_d;

    logic fs_d, fs_bout;

    full_subtractor u_fs (
        .m    (m_q[0]),
        .s    (s_q[0]),
        .bin  (borrow_q),
        .d    (fs_d),
        .bout (fs_bout)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        m_d      = m_q;
        s_d      = s_q;
        res_d    = res_q;
        borrow_d = borrow_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    m_d      = minuend;
                    s_d      = {1'b0, subtrahend};
                    cnt_d    = '0;
                    borrow_d = 1'b0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                // Operands drain from the LSB; difference bits fill from the MSB,
                // so after WIDTH+1 steps the result register is aligned.
                m_d      = m_q >> 1;
                s_d      = s_q >> 1;
                res_d    = {fs_d, res_q[WIDTH:1]};
                borrow_d = fs_bout;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            res_q    <= '0;
            m_q      <= '0;
            s_q      <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            borrow_q <= borrow_d;
            res_q    <= res_d;
            m_q      <= m_d;
            s_q      <= s_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign diff      = res_q;
    assign borrow    = borrow_q;

endmodule

// File: tb/tb_serial_sub_4bit.sv
// Scoreboard bench for serial_sub_4bit: directed vectors, decoupled monitor.
module tb_serial_sub_4bit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] minuend;
    logic [3:0] subtrahend;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] diff;
    logic       borrow;

    serial_sub_4bit #(.WIDTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .minuend    (minuend),
        .subtrahend (subtrahend),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .diff       (diff),
        .borrow     (borrow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] diff;
        logic       borrow;
        int         acc;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    logic prev_ov = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: checks latency on each out_valid rise, pops on handshake.
    always @(negedge clk) begin
        if (in_ready && out_valid) begin
            tests++;
            fails++;
            $display("FAIL ready_valid_overlap: in_ready=1 out_valid=1 (t=%0t)", $time);
        end
        if (out_valid && !prev_ov) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_out_valid: got diff=%0h with no pending operation", diff);
            end else begin
                check("latency", 32'(cyc - sb[0].acc), 32'd5);
            end
        end
        if (out_valid && out_ready && sb.size() != 0) begin
            check("diff", 32'(diff), 32'(sb[0].diff));
            check("borrow", 32'(borrow), 32'(sb[0].borrow));
            void'(sb.pop_front());
        end
        prev_ov <= out_valid;
    end

    task automatic send(input logic [4:0] m, input logic [3:0] s,
                        input logic [4:0] ed, input logic eb, input bit push);
        exp_t e;
        int   n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL in_ready_timeout: got 0 required 1");
        end
        in_valid   = 1'b1;
        minuend    = m;
        subtrahend = s;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (push) begin
            e.diff   = ed;
            e.borrow = eb;
            e.acc    = cyc;
            sb.push_back(e);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: got %0d pending required 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] d0;
        logic       b0;
        int         n;
        int         pa[4] = '{5, 15, 7, 12};
        int         pb[4] = '{9, 15, 0, 6};

        rst_n      = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        minuend    = '0;
        subtrahend = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_borrow", 32'(borrow), 32'd0);
        rst_n = 1'b1;

        // Directed vectors
        send(5'b00011, 4'b0001, 5'b00010, 1'b0, 1'b1); drain();
        send(5'b10000, 4'b1111, 5'b00001, 1'b0, 1'b1); drain();
        send(5'b10100, 4'b1010, 5'b01010, 1'b0, 1'b1); drain();
        send(5'b00011, 4'b0101, 5'b11110, 1'b1, 1'b1); drain();
        send(5'b11111, 4'b1111, 5'b10000, 1'b0, 1'b1); drain();
        send(5'b00000, 4'b1111, 5'b10001, 1'b1, 1'b1); drain();

        // Adder round-trip: (a+b) - a == b
        for (int i = 0; i < 4; i++) begin
            send(5'(pa[i] + pb[i]), 4'(pa[i]), 5'(pb[i]), 1'b0, 1'b1);
            drain();
        end

        // Back-pressure with a stray in_valid pulse while in DONE
        out_ready = 1'b0;
        send(5'b10100, 4'b1010, 5'b01010, 1'b0, 1'b1);
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("bp_out_valid", 32'(out_valid), 32'd1);
        d0 = diff;
        b0 = borrow;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_diff_stable", 32'(diff), 32'(d0));
            check("bp_borrow_stable", 32'(borrow), 32'(b0));
            check("bp_in_ready_low", 32'(in_ready), 32'd0);
            if (i == 0) begin
                in_valid   = 1'b1;
                minuend    = 5'b11111;
                subtrahend = 4'b0001;
            end else begin
                in_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_out_valid", 32'(out_valid), 32'd0);
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        drain();
        repeat (8) @(posedge clk);

        // Reset while bit 2 is being processed
        send(5'b11011, 4'b0110, 5'b00000, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_diff", 32'(diff), 32'd0);
        check("midrst_borrow", 32'(borrow), 32'd0);
        repeat (10) @(posedge clk);
        send(5'b00000, 4'b0000, 5'b00000, 1'b0, 1'b1);
        drain();
        repeat (3) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
